ac_seq: RTL

AC_SEQ -- requirements
Module: ac_seq

---
 rtl/ac_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ac_seq.sv
// ac_seq: accumulator-machine instruction sequencer FSM.
// Optional memory-access timeout enabled by defining AC_SEQ_TIMEOUT_EN.
module ac_seq #(
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [3:0]        opcode,
   input  logic [ADDR_W-1:0] op_addr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   output logic              ac_write_en,
   output logic              ac_sel_alu,
   output logic [2:0]        alu_op,
   output logic              done,
   output logic              err,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_MEM_RD,
      S_EXEC,
      S_WB,
      S_MEM_WR,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic [3:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic              err_q;
   logic              set_err;
   logic              mem_to;

   logic is_nop, is_load, is_store;
   logic is_alu, is_inc;
   logic [2:0] alu_sel;

   assign is_nop   = (op_q == 4'd0);
   assign is_load  = (op_q == 4'd1);
   assign is_store = (op_q == 4'd2);
   assign is_alu   = (op_q >= 4'd3) && (op_q <= 4'd5);
   assign is_inc   = (op_q == 4'd6);

   // ADD/SUB/AND map to alu 1/2/3, INC to 4, everything else pass
   assign alu_sel = is_inc ? 3'd4 :
                    is_alu ? 3'(op_q - 4'd2) : 3'd0;

   assign busy = (state != S_IDLE);

`ifdef AC_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] to_cnt;
   logic          in_mem;

   assign in_mem = (state == S_MEM_RD) ||
                   (state == S_MEM_WR);

   // count consecutive unacknowledged request cycles
   always_ff @(posedge clock) begin
      if (reset || !in_mem || mem_ack)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end

   assign mem_to = in_mem && !mem_ack &&
                   (to_cnt == CW'(TIMEOUT_CYC - 1));
`else
   logic unused_to;
   assign unused_to = (TIMEOUT_CYC != 0);
   assign mem_to    = 1'b0;
`endif

   // state register and latched instruction
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= S_IDLE;
         op_q   <= '0;
         addr_q <= '0;
         err_q  <= 1'b0;
      end else begin
         state <= state_nx;
         if (op_ready && op_valid) begin
            op_q   <= opcode;
            addr_q <= op_addr;
            err_q  <= 1'b0;
         end else if (set_err) begin
            err_q <= 1'b1;
         end
      end
   end

   // next state and Moore outputs
   always_comb begin
      state_nx    = state;
      op_ready    = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      ac_write_en = 1'b0;
      ac_sel_alu  = 1'b0;
      alu_op      = 3'd0;
      done        = 1'b0;
      err         = 1'b0;
      set_err     = 1'b0;
      unique case (state)
         S_IDLE: begin
            op_ready = 1'b1;
            if (op_valid)
               state_nx = S_DECODE;
         end
         S_DECODE: begin
            alu_op = alu_sel;
            unique case (1'b1)
               is_nop:   state_nx = S_DONE;
               is_store: state_nx = S_MEM_WR;
               is_load:  state_nx = S_MEM_RD;
               is_alu:   state_nx = S_MEM_RD;
               is_inc:   state_nx = S_EXEC;
               default: begin
                  state_nx = S_DONE;
                  set_err  = 1'b1;
               end
            endcase
         end
         S_MEM_RD: begin
            alu_op   = alu_sel;
            mem_req  = 1'b1;
            mem_addr = addr_q;
            if (mem_ack)
               state_nx = is_load ? S_WB : S_EXEC;
            else if (mem_to) begin
               state_nx = S_DONE;
               set_err  = 1'b1;
            end
         end
         S_EXEC: begin
            alu_op   = alu_sel;
            state_nx = S_WB;
         end
         S_WB: begin
            alu_op      = alu_sel;
            ac_write_en = 1'b1;
            ac_sel_alu  = !is_load;
            state_nx    = S_DONE;
         end
         S_MEM_WR: begin
            alu_op   = alu_sel;
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = addr_q;
            if (mem_ack)
               state_nx = S_DONE;
            else if (mem_to) begin
               state_nx = S_DONE;
               set_err  = 1'b1;
            end
         end
         S_DONE: begin
            done     = 1'b1;
            err      = err_q;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule
